sipo_rx: RTL and testbench

Serial-in, parallel-out receiver: the receive end of the team's 4-bit PISO serial link. It samples a qualified serial bit stream LSB-first and assembles W-bit words. Each completed word is presented on a registered parallel bus with a one-cycle valid pulse. The block sits at the far end of the serial path and feeds word-wide downstream logic. Framing errors are reported rather than silently absorbed.

---
 rtl/sipo_rx.sv | 106 ++++++++++
 tb/tb_sipo_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in, parallel-out receiver for the 4-bit PISO serial link.
//
// Assembles W-bit words from a qualified serial stream, LSB first. A word
// starts with a bit flagged by sof and completes after W accepted bits.
// Completed words are presented on a registered bus with a one-cycle valid
// pulse. A sof arriving mid-word aborts the partial word and raises a
// one-cycle framing error pulse.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   sin      serial data bit
//   sin_vld  sin carries a valid bit this cycle
//   sof      start of frame, qualified by sin_vld
//   q        last completed word (registered)
//   q_vld    one-cycle pulse, q updated on the preceding edge
//   err      one-cycle pulse, framing error (word restarted mid-word)
module sipo_rx #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    input  logic         sin_vld,
    input  logic         sof,
    output logic [W-1:0] q,
    output logic         q_vld,
    output logic         err
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    sreg_q;
    logic [W-1:0]    q_q;
    logic            q_vld_q;
    logic            err_q;

    // Partial word with the current bit written at position cnt_q, and a fresh
    // word holding only bit 0 for starts and restarts.
    logic [W-1:0] sreg_ins;
    logic [W-1:0] sreg_start;

    always_comb begin
        sreg_ins        = sreg_q;
        sreg_ins[cnt_q] = sin;
        sreg_start      = '0;
        sreg_start[0]   = sin;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            q_q     <= '0;
            q_vld_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_vld_q <= 1'b0;
            err_q   <= 1'b0;
            if (sin_vld) begin
                unique case (state_q)
                    StIdle: begin
                        // Bits outside a frame are dropped silently.
                        if (sof) begin
                            sreg_q  <= sreg_start;
                            cnt_q   <= CntW'(1);
                            state_q <= StShift;
                        end
                    end
                    StShift: begin
                        if (sof) begin
                            // Restart takes priority, including at the final bit.
                            err_q  <= 1'b1;
                            sreg_q <= sreg_start;
                            cnt_q  <= CntW'(1);
                        end else if (cnt_q == CntLast) begin
                            q_q     <= sreg_ins;
                            q_vld_q <= 1'b1;
                            sreg_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            sreg_q <= sreg_ins;
                            cnt_q  <= cnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign q     = q_q;
    assign q_vld = q_vld_q;
    assign err   = err_q;

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       sin_vld;
    logic       sof;
    logic [3:0] q;
    logic       q_vld;
    logic       err;

    int n_cmp;
    int n_bad;

    sipo_rx #(.W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sin     (sin),
        .sin_vld (sin_vld),
        .sof     (sof),
        .q       (q),
        .q_vld   (q_vld),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the falling edge, then return 1 ns after the rising edge.
    task automatic step(input logic v, input logic f, input logic s);
        @(negedge clk);
        sin_vld = v;
        sof     = f;
        sin     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eq, input logic ev,
                              input logic ee);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".q_vld"}, 32'(q_vld), 32'(ev));
        check({tag, ".err"}, 32'(err), 32'(ee));
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        sin     = 1'b0;
        sin_vld = 1'b0;
        sof     = 1'b0;

        // Reset state, with inputs active to show reset dominates.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        expect_out("reset", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word capture: bits 1,0,1,1 -> 4'hD.
        step(1'b1, 1'b1, 1'b1);
        expect_out("cap.b0", 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("cap.b2", 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("cap.done", 4'hD, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("cap.after", 4'hD, 1'b0, 1'b0);

        // Stall: 2 gap cycles after bit 1; sof during a gap must be ignored.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        expect_out("stall.gap1", 4'hD, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("stall.b2", 4'hD, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("stall.done", 4'hD, 1'b1, 1'b0);

        // Back-to-back: 4'hA (0,1,0,1) then 4'h5 (1,0,1,0), no idle cycle.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("b2b.a", 4'hA, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        expect_out("b2b.next0", 4'hA, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("b2b.next2", 4'hA, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("b2b.5", 4'h5, 1'b1, 1'b0);

        // Framing error: sof + 2 bits, then restart with 4'h3 (1,1,0,0).
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        expect_out("ferr.restart", 4'h5, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        expect_out("ferr.clear", 4'h5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("ferr.3", 4'h3, 1'b1, 1'b0);

        // sof at the final bit position restarts: err, no q_vld; then 0,1,1,1 -> 4'hE.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        expect_out("lasterr.restart", 4'h3, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        expect_out("lasterr.b2", 4'h3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("lasterr.E", 4'hE, 1'b1, 1'b0);

        // Reset mid-word, then frame 4'h9 (1,0,0,1).
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        expect_out("rstmid", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Leftover bits of the discarded word must not complete anything.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        expect_out("rstmid.noise", 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("rstmid.9", 4'h9, 1'b1, 1'b0);

        // Idle noise: valid bits without sof while idle are dropped.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'(i));
            expect_out($sformatf("idle%0d", i), 4'h9, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
